// File: rtl/tdc_ctrl_pkg.sv
// Shared types and constants for the TDC measurement sequencer.
// FSM state encoding, miss-counter ceiling and width helpers.
package tdc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    HOLD    = 3'd2,
    CAPTURE = 3'd3,
    ENCODE  = 3'd4,
    OUT     = 3'd5
  } tdc_state_e;

  localparam int unsigned MISS_MAX = 255;

  // Width needed to hold a thermometer count in 0..n_stages.
  function automatic int unsigned code_width(input int unsigned n_stages);
    return $clog2(n_stages + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tdc_therm_enc.sv
// Combinational thermometer-to-binary encoder with bubble detection.
// Code is the run length of ones from bit 0; any one above the first zero flags a bubble.
module tdc_therm_enc
  import tdc_ctrl_pkg::*;
#(
  parameter int unsigned N_STAGES = 16,
  parameter int unsigned CODE_W   = code_width(N_STAGES)
) (
  input  logic [N_STAGES-1:0] therm_i,
  output logic [CODE_W-1:0]   code_o,
  output logic                bubble_o
);

  logic seen_zero;

  always_comb begin
    code_o    = '0;
    bubble_o  = 1'b0;
    seen_zero = 1'b0;
    for (int i = 0; i < int'(N_STAGES); i++) begin
      if (!therm_i[i]) begin
        seen_zero = 1'b1;
      end else if (seen_zero) begin
        bubble_o = 1'b1;
      end else begin
        code_o = CODE_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/tdc_ctrl.sv
// TDC latch-array measurement sequencer: arm, hold/settle, capture, encode, then
// present the code on a valid/ready port. Drops (and counts) starts while busy.
//
// Handshake: out_valid rises when a result is ready and stays high, with out_code
// and out_bubble frozen, until the cycle in which out_ready is also high; that
// cycle is the transfer and the FSM is back in IDLE on the following cycle.
module tdc_ctrl
  import tdc_ctrl_pkg::*;
#(
  parameter int unsigned N_STAGES   = 16,
  parameter int unsigned ARM_CYC    = 2,
  parameter int unsigned SETTLE_CYC = 3,
  parameter int unsigned CODE_W     = code_width(N_STAGES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_STAGES-1:0] tdc_q,
  output logic                tdc_en_bar,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CODE_W-1:0]   out_code,
  output logic                out_bubble,
  output logic [7:0]          miss_cnt,
  output tdc_state_e          dbg_state
);

  localparam int unsigned PH_MAX = max_u(ARM_CYC, SETTLE_CYC);
  localparam int unsigned CNT_W  = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [CNT_W-1:0] ARM_LOAD    = CNT_W'(ARM_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  tdc_state_e          state_q;
  logic [CNT_W-1:0]    phase_q;
  logic [N_STAGES-1:0] cap_q;
  logic                en_bar_q;
  logic                busy_q;
  logic                valid_q;
  logic [CODE_W-1:0]   code_q;
  logic                bubble_q;
  logic [7:0]          miss_q;

  logic [CODE_W-1:0]   enc_code_d;
  logic                enc_bubble_d;

  tdc_therm_enc #(
    .N_STAGES (N_STAGES),
    .CODE_W   (CODE_W)
  ) u_enc (
    .therm_i  (cap_q),
    .code_o   (enc_code_d),
    .bubble_o (enc_bubble_d)
  );

  // Phase counter counts down from LOAD to 0, so each phase lasts LOAD+1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      cap_q    <= '0;
      en_bar_q <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      code_q   <= '0;
      bubble_q <= 1'b0;
      miss_q   <= '0;
    end else begin
      if (start && (state_q != IDLE) && (miss_q != 8'(MISS_MAX))) begin
        miss_q <= miss_q + 8'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= ARM;
            en_bar_q <= 1'b0;
            busy_q   <= 1'b1;
            phase_q  <= ARM_LOAD;
          end
        end
        ARM: begin
          if (phase_q == '0) begin
            state_q  <= HOLD;
            en_bar_q <= 1'b1;
            phase_q  <= SETTLE_LOAD;
          end else begin
            phase_q <= phase_q - CNT_W'(1);
          end
        end
        HOLD: begin
          if (phase_q == '0) begin
            state_q <= CAPTURE;
          end else begin
            phase_q <= phase_q - CNT_W'(1);
          end
        end
        CAPTURE: begin
          cap_q   <= tdc_q;
          state_q <= ENCODE;
        end
        ENCODE: begin
          code_q   <= enc_code_d;
          bubble_q <= enc_bubble_d;
          valid_q  <= 1'b1;
          state_q  <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tdc_en_bar = en_bar_q;
  assign busy       = busy_q;
  assign out_valid  = valid_q;
  assign out_code   = code_q;
  assign out_bubble = bubble_q;
  assign miss_cnt   = miss_q;
  assign dbg_state  = state_q;

endmodule
